// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings and sequencer state
// for the ALU issue/capture stage.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_SLT  = 3'b011,
    OP_AND  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_OR   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request and response handshakes
// of the ALU sequencer bundled for the issuing side.
interface alu_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_carryout;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic [2:0]       rsp_sel;

  modport master (
    output req_valid, req_a, req_b, req_sel,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_out, rsp_carryout,
    input  rsp_zero, rsp_overflow, rsp_sel
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_out, rsp_carryout,
    output rsp_zero, rsp_overflow, rsp_sel
  );

endinterface

// File: rtl/ALU32Bit.sv
// ALU32Bit: 32-bit combinational ALU; add/sub share one
// adder, SLT is the sign of a-b corrected for overflow.
module ALU32Bit
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  output logic [31:0] out,
  output logic        carryout,
  output logic        zero,
  output logic        overflow
);

  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        ovf;

  // shared adder and result mux
  always_comb begin
    sub      = (sel == OP_SUB) || (sel == OP_SLT);
    b_eff    = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub};
    ovf      = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    out      = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    unique case (op_e'(sel))
      OP_ADD, OP_SUB: begin
        out      = sum[31:0];
        carryout = sum[32];
        overflow = ovf;
      end
      OP_XOR:  out = a ^ b;
      OP_SLT:  out = {31'b0, sum[31] ^ ovf};
      OP_AND:  out = a & b;
      OP_NAND: out = ~(a & b);
      OP_NOR:  out = ~(a | b);
      OP_OR:   out = a | b;
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: registers requests onto the ALU inputs,
// waits a settle interval, then captures the response.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  input  logic [2:0]             req_sel,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_carryout,
  input  logic                   alu_zero,
  input  logic                   alu_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_out,
  output logic                   rsp_carryout,
  output logic                   rsp_zero,
  output logic                   rsp_overflow,
  output logic [2:0]             rsp_sel,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] op_count
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [2:0]             sel_q, sel_d;
  logic                   vld_q, vld_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   c_q, c_d, z_q, z_d, v_q, v_d;
  logic [2:0]             rsel_q, rsel_d;
  logic [COUNT_WIDTH-1:0] cnt_op_q, cnt_op_d;
  logic                   accept;

  // handshake decode, next-state and datapath loads
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    vld_d    = vld_q;
    out_d    = out_q;
    c_d      = c_q;
    z_d      = z_q;
    v_d      = v_q;
    rsel_d   = rsel_q;
    cnt_op_d = cnt_op_q;
    req_ready = (state_q == ST_IDLE) ||
                ((state_q == ST_RESP) && rsp_ready);
    accept = req_valid && req_ready;
    unique case (state_q)
      ST_IDLE: ;
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_d   = alu_out;
          c_d     = alu_carryout;
          z_d     = alu_zero;
          v_d     = alu_overflow;
          rsel_d  = sel_q;
          vld_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_op_d = cnt_op_q + 1'b1;
          vld_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      a_d     = req_a;
      b_d     = req_b;
      sel_d   = req_sel;
      cnt_d   = CNT_LOAD;
      state_d = ST_SETTLE;
    end
  end

  // state and datapath registers, sync active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      vld_q    <= 1'b0;
      out_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      rsel_q   <= '0;
      cnt_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      vld_q    <= vld_d;
      out_q    <= out_d;
      c_q      <= c_d;
      z_q      <= z_d;
      v_q      <= v_d;
      rsel_q   <= rsel_d;
      cnt_op_q <= cnt_op_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_sel      = sel_q;
  assign rsp_valid    = vld_q;
  assign rsp_out      = out_q;
  assign rsp_carryout = c_q;
  assign rsp_zero     = z_q;
  assign rsp_overflow = v_q;
  assign rsp_sel      = rsel_q;
  assign busy         = (state_q == ST_SETTLE);
  assign op_count     = cnt_op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: alu_sequencer with ALU32Bit beside it,
// checked against a plain-arithmetic reference model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int SC   = 4;
  localparam int CWID = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(W)) bus();

  logic [W-1:0]    alu_a, alu_b, alu_out;
  logic [2:0]      alu_sel;
  logic            alu_c, alu_z, alu_v, busy;
  logic [CWID-1:0] op_count;

  alu_sequencer #(
    .WIDTH(W), .SETTLE_CYCLES(SC), .COUNT_WIDTH(CWID)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(bus.req_valid), .req_ready(bus.req_ready),
    .req_a(bus.req_a), .req_b(bus.req_b),
    .req_sel(bus.req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carryout(alu_c),
    .alu_zero(alu_z), .alu_overflow(alu_v),
    .rsp_valid(bus.rsp_valid), .rsp_ready(bus.rsp_ready),
    .rsp_out(bus.rsp_out),
    .rsp_carryout(bus.rsp_carryout),
    .rsp_zero(bus.rsp_zero),
    .rsp_overflow(bus.rsp_overflow),
    .rsp_sel(bus.rsp_sel),
    .busy(busy), .op_count(op_count)
  );

  ALU32Bit u_alu (
    .a(alu_a), .b(alu_b), .sel(alu_sel),
    .out(alu_out), .carryout(alu_c),
    .zero(alu_z), .overflow(alu_v)
  );

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  typedef struct packed {
    logic [31:0] out;
    logic        c;
    logic        z;
    logic        v;
  } res_t;

  function automatic res_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [2:0] sel);
    res_t r;
    logic [32:0] s;
    r = '0;
    s = '0;
    case (sel)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r.out = s[31:0];
        r.c = s[32];
        r.v = (a[31] == b[31]) && (r.out[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.out = s[31:0];
        r.c = s[32];
        r.v = (a[31] != b[31]) && (r.out[31] != a[31]);
      end
      3'd2: r.out = a ^ b;
      3'd3: r.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r.out = a & b;
      3'd5: r.out = ~(a & b);
      3'd6: r.out = ~(a | b);
      default: r.out = a | b;
    endcase
    r.z = (r.out == 32'd0);
    return r;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_count = 0;
  endtask

  // one full operation; returns what was observed
  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [2:0] sel,
                        input int stall,
                        output int lat,
                        output res_t got,
                        output logic [2:0] gsel,
                        output bit stable);
    bus.req_a = a;
    bus.req_b = b;
    bus.req_sel = sel;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.req_ready; i++)
      @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = {bus.rsp_out, bus.rsp_carryout,
           bus.rsp_zero, bus.rsp_overflow};
    gsel = bus.rsp_sel;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if ({bus.rsp_valid, bus.rsp_out, bus.rsp_carryout,
           bus.rsp_zero, bus.rsp_overflow, bus.rsp_sel}
          !== {1'b1, got, gsel})
        stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    if (lat < 50) exp_count++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", bus.req_ready);
    end
    checks++;
    if ({alu_a, alu_b, alu_sel} !== '0) begin
      errors++;
      $display("FAIL rst_alu: got %h %h %b want 0",
               alu_a, alu_b, alu_sel);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_out, bus.rsp_carryout,
         bus.rsp_zero, bus.rsp_overflow, bus.rsp_sel} !== '0) begin
      errors++;
      $display("FAIL rst_rsp: got v=%b out=%h sel=%b want 0",
               bus.rsp_valid, bus.rsp_out, bus.rsp_sel);
    end
    checks++;
    if ({busy, op_count} !== '0) begin
      errors++;
      $display("FAIL rst_busy_cnt: got busy=%b cnt=%0d want 0",
               busy, op_count);
    end
  endtask

  task automatic test_add();
    int lat;
    res_t got;
    logic [2:0] gsel;
    bit st;
    run_op(32'h0000_2001, 32'h1, OP_ADD, 0, lat, got, gsel, st);
    checks++;
    if (lat != SC) begin
      errors++;
      $display("FAIL add_lat: got %0d want %0d", lat, SC);
    end
    checks++;
    if (got !== {32'h0000_2002, 3'b000}) begin
      errors++;
      $display("FAIL add_res: got %h/%b%b%b want 00002002/000",
               got.out, got.c, got.z, got.v);
    end
    checks++;
    if (op_count !== CWID'(exp_count)) begin
      errors++;
      $display("FAIL add_count: got %0d want %0d",
               op_count, exp_count);
    end
  endtask

  task automatic test_sub_zero();
    int lat;
    res_t got;
    logic [2:0] gsel;
    bit st;
    run_op(32'h8000_0001, 32'h8000_0001, OP_SUB, 2,
           lat, got, gsel, st);
    checks++;
    if (got !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_zero: got %h c=%b z=%b v=%b want 0 1 1 0",
               got.out, got.c, got.z, got.v);
    end
    checks++;
    if (gsel !== OP_SUB || !st) begin
      errors++;
      $display("FAIL sub_sel_stable: got sel=%b st=%b want 001 1",
               gsel, st);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit stable;
    res_t exp1, exp2;
    exp1 = model(32'd5, 32'd3, OP_SUB);
    exp2 = model(32'h10, 32'h20, OP_OR);
    bus.req_a = 32'd5;
    bus.req_b = 32'd3;
    bus.req_sel = OP_SUB;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, bus.req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL bp_settle: got busy=%b ready=%b want 1 0",
               busy, bus.req_ready);
    end
    bus.req_a = 32'h10;
    bus.req_b = 32'h20;
    bus.req_sel = OP_OR;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({bus.rsp_valid, bus.rsp_out, bus.req_ready,
           alu_a, alu_sel}
          !== {1'b1, exp1.out, 1'b0, 32'd5, OP_SUB})
        stable = 1'b0;
    end
    checks++;
    if (!stable || lat != SC) begin
      errors++;
      $display("FAIL bp_hold: got stable=%b lat=%0d want 1 %0d",
               stable, lat, SC);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_comb: got %b want 1",
               bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    exp_count++;
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, busy, alu_a, alu_sel, op_count}
        !== {1'b0, 1'b1, 32'h10, OP_OR, CWID'(exp_count)}) begin
      errors++;
      $display("FAIL bp_b2b: got v=%b busy=%b a=%h sel=%b cnt=%0d want 0 1 10 111 %0d",
               bus.rsp_valid, busy, alu_a, alu_sel,
               op_count, exp_count);
    end
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat != SC || bus.rsp_out !== exp2.out ||
        bus.rsp_sel !== OP_OR) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d out=%h sel=%b want %0d %h 111",
               lat, bus.rsp_out, bus.rsp_sel, SC, exp2.out);
    end
    @(posedge clk);
    @(negedge clk);
    exp_count++;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_throughput();
    int seen[$];
    int extra;
    bus.req_a = 32'd7;
    bus.req_b = 32'd9;
    bus.req_sel = OP_ADD;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen.push_back(cyc);
    end
    bus.req_valid = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) extra++;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (seen.size() < 6) begin
      errors++;
      $display("FAIL tp_count: got %0d want >=6", seen.size());
    end
    for (int i = 1; i < seen.size(); i++) begin
      checks++;
      if (seen[i] - seen[i-1] != SC + 1) begin
        errors++;
        $display("FAIL tp_interval: got %0d want %0d",
                 seen[i] - seen[i-1], SC + 1);
      end
    end
    exp_count += seen.size() + extra;
    checks++;
    if (op_count !== CWID'(exp_count)) begin
      errors++;
      $display("FAIL tp_opcount: got %0d want %0d",
               op_count, exp_count % 16);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen_v;
    res_t got, exp;
    logic [2:0] gsel;
    bit st;
    bus.req_a = 32'd1;
    bus.req_b = 32'd2;
    bus.req_sel = OP_ADD;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_count = 0;
    seen_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || busy) seen_v = 1'b1;
    end
    checks++;
    if (seen_v || op_count !== '0 || alu_a !== '0) begin
      errors++;
      $display("FAIL rstmid_abort: got v=%b cnt=%0d a=%h want 0 0 0",
               seen_v, op_count, alu_a);
    end
    bus.rsp_ready = 1'b0;
    exp = model(32'hFFFF_FFFF, 32'd1, OP_ADD);
    run_op(32'hFFFF_FFFF, 32'd1, OP_ADD, 0, lat, got, gsel, st);
    checks++;
    if (lat != SC || got !== exp || op_count !== CWID'(1)) begin
      errors++;
      $display("FAIL rstmid_next: got lat=%0d res=%h cnt=%0d want %0d %h 1",
               lat, got, op_count, SC, exp);
    end
  endtask

  task automatic test_random();
    int lat;
    res_t got, exp;
    logic [2:0] gsel;
    bit st;
    logic [31:0] a, b;
    logic [31:0] edges [4];
    edges[0] = 32'h7FFF_FFFF;
    edges[1] = 32'h8000_0000;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      a = (i % 4 == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      b = (i % 5 == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      if (i % 7 == 0) b = a;
      exp = model(a, b, 3'(i % 8));
      run_op(a, b, 3'(i % 8), $urandom_range(0, 3),
             lat, got, gsel, st);
      checks++;
      if (got !== exp || gsel !== 3'(i % 8) ||
          lat != SC || !st) begin
        errors++;
        $display("FAIL rand_op%0d: got %h/%b%b%b sel=%b lat=%0d st=%b want %h/%b%b%b sel=%b lat=%0d",
                 i, got.out, got.c, got.z, got.v, gsel, lat, st,
                 exp.out, exp.c, exp.z, exp.v, 3'(i % 8), SC);
      end
    end
    checks++;
    if (op_count !== CWID'(exp_count)) begin
      errors++;
      $display("FAIL rand_opcount: got %0d want %0d",
               op_count, exp_count % 16);
    end
  endtask

  task automatic test_wrap();
    int lat;
    res_t got;
    logic [2:0] gsel;
    bit st;
    apply_reset();
    for (int i = 0; i < 17; i++)
      run_op($urandom, $urandom, 3'($urandom_range(0, 7)), 0,
             lat, got, gsel, st);
    checks++;
    if (op_count !== CWID'(1) || exp_count != 17) begin
      errors++;
      $display("FAIL wrap: got %0d want 1 after %0d ops",
               op_count, exp_count);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sel = '0;
    test_reset();
    test_add();
    test_sub_zero();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
